// File: rtl/led_sweep_engine.sv
// LED animation engine: self-timed bouncing sweep / fill bar while cooking,
// freeze on pause, and a timed all-LED flash when cooking completes.
module led_sweep_engine #(
    parameter int N_LEDS     = 16,
    parameter int SHIFT_LO   = 22,
    parameter int SHIFT_NORM = 21,
    parameter int SHIFT_HI   = 20,
    parameter int FLASH_CNT  = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              idle,
    input  logic              pause,
    input  logic              done,
    input  logic [1:0]        mode,
    input  logic              style,
    output logic [N_LEDS-1:0] LED,
    output logic              busy
);

    localparam int DIV_W = (SHIFT_LO > SHIFT_NORM)
                         ? ((SHIFT_LO > SHIFT_HI) ? SHIFT_LO : SHIFT_HI)
                         : ((SHIFT_NORM > SHIFT_HI) ? SHIFT_NORM : SHIFT_HI);
    localparam int POS_W = $clog2(N_LEDS);
    localparam int FL_W  = $clog2(FLASH_CNT + 1);

    localparam logic [DIV_W-1:0] TERM_LO   = DIV_W'((64'd1 << SHIFT_LO) - 64'd1);
    localparam logic [DIV_W-1:0] TERM_NORM = DIV_W'((64'd1 << SHIFT_NORM) - 64'd1);
    localparam logic [DIV_W-1:0] TERM_HI   = DIV_W'((64'd1 << SHIFT_HI) - 64'd1);
    localparam logic [POS_W-1:0] POS_MAX    = POS_W'(N_LEDS - 1);
    localparam logic [FL_W-1:0]  FLASH_LAST = FL_W'(FLASH_CNT - 1);

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_FLASH} state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [FL_W-1:0]   flash_q, flash_d;
    logic [1:0]        mode_q;
    logic [N_LEDS-1:0] led_d;
    logic [DIV_W-1:0]  term;
    logic              tick_en, tick;

    function automatic logic [N_LEDS-1:0] pattern(input logic [POS_W-1:0] p, input logic fill);
        logic [N_LEDS-1:0] bits;
        bits = '0;
        for (int i = 0; i < N_LEDS; i++)
            bits[i] = fill ? (i <= int'(p)) : (i == int'(p));
        return bits;
    endfunction

    // FLASH always runs at the high rate regardless of mode.
    always_comb begin
        term    = TERM_NORM;
        tick_en = 1'b1;
        if (state_q == S_FLASH) begin
            term = TERM_HI;
        end else begin
            case (mode)
                2'b01:   term = TERM_LO;
                2'b10:   term = TERM_NORM;
                2'b11:   term = TERM_HI;
                default: tick_en = 1'b0;
            endcase
        end
        tick = tick_en && (div_q == term);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        div_d   = div_q;
        flash_d = flash_q;
        led_d   = LED;

        case (state_q)
            S_IDLE: begin
                led_d = '0;
                pos_d = '0;
                dir_d = DIR_UP;
                div_d = '0;
                if (!idle && start && mode != 2'b00) begin
                    state_d = S_RUN;
                    led_d   = pattern('0, style);
                end
            end

            S_RUN, S_HOLD: begin
                if (idle) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                    pos_d   = '0;
                    dir_d   = DIR_UP;
                    div_d   = '0;
                end else if (done) begin
                    state_d = S_FLASH;
                    flash_d = '0;
                    div_d   = '0;
                    led_d   = '1;
                end else if (state_q == S_HOLD) begin
                    if (!pause) state_d = S_RUN;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else begin
                    if (mode == 2'b00) begin
                        div_d = '0;
                    end else if (tick) begin
                        div_d = '0;
                        if (dir_q == DIR_UP) begin
                            pos_d = pos_q + 1'b1;
                            if (pos_d == POS_MAX) dir_d = DIR_DN;
                        end else begin
                            pos_d = pos_q - 1'b1;
                            if (pos_d == '0) dir_d = DIR_UP;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                    led_d = pattern(pos_d, style);
                end
            end

            S_FLASH: begin
                if (idle) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                    div_d   = '0;
                end else if (tick) begin
                    div_d = '0;
                    if (flash_q == FLASH_LAST) begin
                        state_d = S_IDLE;
                        flash_d = '0;
                        led_d   = '0;
                    end else begin
                        flash_d = flash_q + 1'b1;
                        led_d   = ~LED;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        // A rate change restarts the divider so the new period starts cleanly.
        if (mode != mode_q) div_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            div_q   <= '0;
            flash_q <= '0;
            mode_q  <= 2'b00;
            LED     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            flash_q <= flash_d;
            mode_q  <= mode;
            LED     <= led_d;
            busy    <= (state_d != S_IDLE);
        end
    end

endmodule

// File: doc/led_sweep_engine.md
Name: led_sweep_engine

Overview:
Parametrised LED animation engine for the microwave front panel. It generates its own per-mode tick rate from sys_clk and drives an N-wide LED bank. The bank shows a bouncing one-hot sweep or a growing fill bar while cooking, freezes on pause, and plays a timed all-LED flash when cooking completes. It replaces the fixed 16-LED speed-select/counter/decoder chain with a single block under one FSM.

Parameters:
N_LEDS, 16, LED count; must be >= 2
SHIFT_LO, 22, tick period exponent for mode 2'b01; tick every 2^SHIFT_LO clocks
SHIFT_NORM, 21, tick period exponent for mode 2'b10
SHIFT_HI, 20, tick period exponent for mode 2'b11; also the FLASH rate
FLASH_CNT, 6, number of flash ticks before returning to IDLE

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-low reset
start  in  1  level/pulse; begins animation from IDLE
idle  in  1  force return to IDLE (highest priority)
pause  in  1  high = freeze animation (door open / paused)
done  in  1  single-cycle pulse; cook finished, triggers flash
mode  in  2  00 = stopped, 01 = low, 10 = normal, 11 = high
style  in  1  0 = bouncing one-hot sweep, 1 = fill bar
LED  out  N_LEDS  registered LED drive, bit 0 = leftmost LED
busy  out  1  high in RUN, HOLD, FLASH

Behaviour:
- Reset (sys_rst=0, async): state=IDLE, LED=0, busy=0, pos=0, dir=up, div_cnt=0, flash_cnt=0.
- Tick generator: div_cnt width = max SHIFT. A tick is a one-cycle strobe when div_cnt == 2^SHIFT_sel − 1; div_cnt wraps to 0 on the same edge. SHIFT_sel comes from mode, or SHIFT_HI in FLASH. mode 00 outside FLASH: no ticks, div_cnt held at 0. div_cnt clears on any mode change and on entry to RUN or FLASH.
- FSM states: IDLE, RUN, HOLD, FLASH. Transition priority per cycle: idle > done > pause > start.
- IDLE: LED=0, pos=0, dir=up. start=1 with mode!=00 → RUN; start with mode==00 is ignored.
- RUN: on each tick, advance pos with bounce.
  - Up direction: pos increments until it reaches N_LEDS−1, then dir flips to down.
  - Down direction: pos decrements until it reaches 0, then dir flips to up.
  - Each endpoint shows for one tick. Period = 2·N_LEDS−2 ticks.
  - pause=1 → HOLD.
- HOLD: pos, dir and LED frozen; div_cnt held. pause=0 → RUN; counting resumes from the held div_cnt.
- From RUN or HOLD: done=1 → FLASH (flash_cnt=0, LED=all ones); idle=1 → IDLE.
- FLASH: on each tick, LED inverts and flash_cnt increments. When flash_cnt reaches FLASH_CNT → IDLE (LED=0). Only idle aborts FLASH; done, pause and start are ignored.
- LED pattern in RUN/HOLD:
  - style=0: LED = one-hot at bit pos.
  - style=1: bits 0..pos set.
  - style may change mid-run; it takes effect on the next cycle without moving pos.
- Latency: LED and busy are registered. LED reflects a state or pos change one cycle after the causing edge, i.e. LED shows the new pos the cycle after the tick. On start, LED = pattern(pos=0) the cycle after start is sampled.
- busy=1 from the cycle after entry to RUN until the cycle after the return to IDLE.
- mode change in RUN updates the rate only; pos and dir are unaffected. mode=00 in RUN freezes the sweep but stays in RUN.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
All scenarios use N_LEDS=4, SHIFT_LO=3, SHIFT_NORM=2, SHIFT_HI=1, FLASH_CNT=4.
1. Reset mid-RUN → LED=0000, busy=0 asynchronously. After release with start=0 → LED stays 0000.
2. mode=10, style=0, start pulse → LED 0001 next cycle, then every 4 clocks: 0010, 0100, 1000, 0100, 0010, 0001, 0010.
3. mode=01, style=1, start → LED 0001, 0011, 0111, 1111, 0111 at 8-clock intervals. Switch style to 0 mid-run → LED one-hot at the same pos on the next cycle.
4. RUN at LED=0100, pause high for 20 clocks → LED constant 0100, busy=1. Pause low → next change after the remaining divider count.
5. done pulse in RUN → LED 1111, then toggling 0000/1111 every 2 clocks for 4 ticks, then IDLE, LED=0000, busy=0. start during FLASH is ignored.
6. Priority and ignore cases:
   - idle and done asserted in the same RUN cycle → IDLE, no flash.
   - mode=00 with start in IDLE → stays IDLE.
   - mode set to 00 in RUN → LED frozen, busy=1.
